// File: rtl/m31_poseidon2_sponge.sv
// Overwrite-mode, padding-free sponge controller around a free-running Poseidon2
// permutation pipeline over M31; emits a DIGEST-element digest per message.
module m31_poseidon2_sponge #(
    parameter int WIDTH        = 16,
    parameter int RATE         = 8,
    parameter int DIGEST       = 8,
    parameter int PERM_LATENCY = 30
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [30:0]           in_data,
    input  logic                  in_last,
    output logic [WIDTH*31-1:0]   perm_state_o,
    input  logic [WIDTH*31-1:0]   perm_state_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIGEST*31-1:0]  out_digest,
    output logic                  busy
);

    localparam int          IDX_W = (RATE > 1) ? $clog2(RATE) : 1;
    localparam int          CNT_W = $clog2(PERM_LATENCY + 1);
    localparam logic [30:0] P     = 31'h7FFF_FFFF;

    typedef enum logic [1:0] {ABSORB, PERMUTE, SQUEEZE} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_flag_q, last_flag_d;
    logic [30:0]        s_q [WIDTH];
    logic [30:0]        s_d [WIDTH];
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [30:0]        in_canon;

    // P itself is the non-canonical encoding of zero.
    assign in_canon = (in_data == P) ? 31'd0 : in_data;

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        last_flag_d = last_flag_q;
        for (int i = 0; i < WIDTH; i++) s_d[i] = s_q[i];

        case (state_q)
            ABSORB: begin
                if (in_valid && in_ready_q) begin
                    for (int i = 0; i < RATE; i++)
                        if (idx_q == IDX_W'(i)) s_d[i] = in_canon;
                    if (idx_q == IDX_W'(RATE - 1) || in_last) begin
                        cnt_d       = CNT_W'(PERM_LATENCY - 1);
                        last_flag_d = in_last;
                        idx_d       = '0;
                        state_d     = PERMUTE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PERMUTE: begin
                if (cnt_q == '0) begin
                    // The pipeline output is only meaningful on this one edge.
                    for (int i = 0; i < WIDTH; i++) s_d[i] = perm_state_i[31*i +: 31];
                    state_d = last_flag_q ? SQUEEZE : ABSORB;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SQUEEZE: begin
                if (out_ready) begin
                    for (int i = 0; i < WIDTH; i++) s_d[i] = '0;
                    state_d = ABSORB;
                end
            end
            default: state_d = ABSORB;
        endcase

        in_ready_d  = (state_d == ABSORB);
        out_valid_d = (state_d == SQUEEZE);
        busy_d      = !(state_d == ABSORB && idx_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ABSORB;
            idx_q       <= '0;
            cnt_q       <= '0;
            last_flag_q <= 1'b0;
            // NOTE: the state array is reset because a new message must start from an all-zero state.
            for (int i = 0; i < WIDTH; i++) s_q[i] <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            last_flag_q <= last_flag_d;
            for (int i = 0; i < WIDTH; i++) s_q[i] <= s_d[i];
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        perm_state_o = '0;
        for (int i = 0; i < WIDTH; i++) perm_state_o[31*i +: 31] = s_q[i];
        out_digest = '0;
        for (int i = 0; i < DIGEST; i++) out_digest[31*i +: 31] = out_valid_q ? s_q[i] : 31'd0;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_m31_poseidon2_sponge.sv
// Directed bench for m31_poseidon2_sponge; the permutation is stubbed as a
// PERM_LATENCY-deep delay line that adds 1 mod P to every element.
module tb_m31_poseidon2_sponge;

    localparam int          W = 16;
    localparam int          R = 8;
    localparam int          D = 8;
    localparam int          L = 30;
    localparam logic [30:0] P = 31'h7FFF_FFFF;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready, in_last;
    logic [30:0]       in_data;
    logic [W*31-1:0]   perm_state_o, perm_state_i;
    logic              out_valid, out_ready;
    logic [D*31-1:0]   out_digest;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [30:0] exp_dig [D];

    m31_poseidon2_sponge #(.WIDTH(W), .RATE(R), .DIGEST(D), .PERM_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .perm_state_o(perm_state_o), .perm_state_i(perm_state_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_digest(out_digest),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W*31-1:0] bump(input logic [W*31-1:0] v);
        logic [W*31-1:0] r;
        logic [30:0]     e;
        r = '0;
        for (int i = 0; i < W; i++) begin
            e = v[31*i +: 31];
            r[31*i +: 31] = (e == P - 31'd1) ? 31'd0 : e + 31'd1;
        end
        return r;
    endfunction

    // L-1 registers: the state written at edge E0 is presented before edge E(L).
    logic [W*31-1:0] pipe [L-1];
    always @(posedge clk) begin
        pipe[0] <= bump(perm_state_o);
        for (int i = 1; i < L - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign perm_state_i = pipe[L-2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_digest(input string tag);
        for (int i = 0; i < D; i++)
            check($sformatf("%s_d%0d", tag, i), 64'(out_digest[31*i +: 31]), 64'(exp_dig[i]));
    endtask

    task automatic send(input logic [30:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("send_timeout", 64'd0, 64'd1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    endtask

    // Counts low cycles of out_valid (and in_ready) from the current negedge.
    task automatic wait_digest(output int lat, output int ir_low);
        lat = 0; ir_low = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) ir_low++;
            lat++;
            @(negedge clk);
        end
        if (lat >= 100) check("digest_timeout", 64'd0, 64'd1);
    endtask

    task automatic accept(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_s_zero"},  64'(perm_state_o == '0), 64'd1);
        check({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat, ir_low, seen;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_digest", 64'(out_digest == '0), 64'd1);
        check("rst_state", 64'(perm_state_o == '0), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single full block
        for (int v = 1; v <= 8; v++) send(31'(v), v == 8);
        wait_digest(lat, ir_low);
        check("full_latency", 64'(lat), 64'd30);
        check("full_rdy_low", 64'(ir_low), 64'd30);
        exp_dig = '{31'd2, 31'd3, 31'd4, 31'd5, 31'd6, 31'd7, 31'd8, 31'd9};
        check_digest("full");
        accept("full");

        // Partial block, then backpressure in SQUEEZE
        send(31'd5, 1'b0);
        check("partial_busy", 64'(busy), 64'd1);
        send(31'd6, 1'b0);
        send(31'd7, 1'b1);
        wait_digest(lat, ir_low);
        check("partial_latency", 64'(lat), 64'd30);
        exp_dig = '{31'd6, 31'd7, 31'd8, 31'd1, 31'd1, 31'd1, 31'd1, 31'd1};
        check_digest("partial");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_digest1", 64'(out_digest[31 +: 31]), 64'd7);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        accept("bp");

        // Two blocks; block 2 overwrites elements 0..3 only
        for (int v = 1; v <= 8; v++) send(31'(v), 1'b0);
        lat = 0;
        while (!in_ready && lat < 100) begin lat++; @(negedge clk); end
        check("blk1_rdy_low", 64'(lat), 64'd30);
        check("blk1_s0", 64'(perm_state_o[0 +: 31]), 64'd2);
        check("blk1_s8", 64'(perm_state_o[8*31 +: 31]), 64'd1);
        check("blk1_out_valid", 64'(out_valid), 64'd0);
        for (int v = 9; v <= 12; v++) send(31'(v), v == 12);
        wait_digest(lat, ir_low);
        exp_dig = '{31'd10, 31'd11, 31'd12, 31'd13, 31'd7, 31'd8, 31'd9, 31'd10};
        check_digest("two");
        accept("two");

        // Non-canonical zero encoding
        send(P, 1'b0);
        check("noncanon_s0", 64'(perm_state_o[0 +: 31]), 64'd0);
        send(31'd3, 1'b1);
        wait_digest(lat, ir_low);
        check("noncanon_d0", 64'(out_digest[0 +: 31]), 64'd1);
        check("noncanon_d1", 64'(out_digest[31 +: 31]), 64'd4);
        check("noncanon_d2", 64'(out_digest[62 +: 31]), 64'd1);
        accept("noncanon");

        // Reset mid-PERMUTE
        send(31'd7, 1'b1);
        repeat (9) @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_busy", 64'(busy), 64'd0);
        check("async_state", 64'(perm_state_o == '0), 64'd1);
        check("async_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_no_digest", 64'(seen), 64'd0);
        send(31'd4, 1'b1);
        wait_digest(lat, ir_low);
        check("post_rst_latency", 64'(lat), 64'd30);
        exp_dig = '{31'd5, 31'd1, 31'd1, 31'd1, 31'd1, 31'd1, 31'd1, 31'd1};
        check_digest("post_rst");
        accept("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/m31_poseidon2_sponge.md
Name: m31_poseidon2_sponge

Overview:
- Sponge controller for hashing a variable-length stream of M31 elements, using overwrite-mode, padding-free absorption.
- Wraps the free-running, valid-less Poseidon2 permutation pipeline:
  - upstream, it builds each WIDTH-element state and drives it into the pipeline input;
  - downstream, it captures the permuted state exactly PERM_LATENCY cycles later.
- Emits a DIGEST-element digest per message over a valid/ready stream.

Parameters:
- WIDTH, 16, permutation state width in M31 elements (multiple of 4).
- RATE, 8, elements absorbed per permutation (1..WIDTH-1).
- DIGEST, 8, elements output per message (1..RATE).
- PERM_LATENCY, 30, cycles from perm_state_o update edge to the edge at which perm_state_i holds that state's permutation (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  input element valid.
- in_ready  out  1  controller accepts an element.
- in_data  in  31  M31 element.
- in_last  in  1  final element of message (qualified by in_valid).
- perm_state_o  out  WIDTH*31  state to permutation, element i at bits [31i+30:31i].
- perm_state_i  in  WIDTH*31  permutation output.
- out_valid  out  1  digest valid.
- out_ready  in  1  digest consumer ready.
- out_digest  out  DIGEST*31  state elements 0..DIGEST-1.
- busy  out  1  high in any state except ABSORB with idx==0.

Behaviour:
- State register S[WIDTH] drives perm_state_o directly.
- Reset (async, rst_n low):
  - S=0; FSM=ABSORB; idx=0; cnt=0; last_flag=0.
  - Outputs: in_ready=0 during reset, out_valid=0, out_digest=0, busy=0.
  - Reset mid-operation discards everything; pipeline outputs still in flight are never captured.
- Input canonicalisation: in_data==0x7FFFFFFF is written as 0; all other values are written unchanged.
- ABSORB: in_ready=1. On handshake (in_valid&in_ready):
  - S[idx]<=canon(in_data).
  - If idx==RATE-1 or in_last:
    - cnt<=PERM_LATENCY-1; last_flag<=in_last; idx<=0; go to PERMUTE.
  - Else idx<=idx+1.
  - Elements S[idx+1..WIDTH-1] retain their prior values (padding-free overwrite).
- PERMUTE:
  - in_ready=0; S is held stable.
  - cnt decrements each cycle.
  - At the edge where cnt==0: S<=perm_state_i.
    - Capture occurs PERM_LATENCY edges after the edge that wrote the final block element.
    - Then go to SQUEEZE if last_flag, else ABSORB.
- SQUEEZE:
  - out_valid=1; out_digest=S[0..DIGEST-1], stable while out_ready is low; in_ready=0.
  - On out_ready: S<=0; out_valid deasserts the next cycle; go to ABSORB (idx=0).
- out_digest is driven from S only in SQUEEZE; it is 0 otherwise.
- Zero-length messages are not supported; in_last is always carried by an element.
- Simultaneous in_valid during PERMUTE/SQUEEZE: not accepted, and the source holds the element.
- Throughput per full block: RATE accept cycles plus PERM_LATENCY stall cycles.
- The pipeline sees intermediate S values during ABSORB. Its outputs are ignored except at the capture edge.

Test Plan:
All scenarios use the bench stub permutation: a PERM_LATENCY-deep delay line outputting element+1 mod P. PERM_LATENCY=30 unless stated.
- Single full block: elements 1..8, in_last on 8 → in_ready low exactly 30 cycles. out_valid rises 30 edges after the last handshake; digest=[2,3,4,5,6,7,8,9].
- Partial block: elements 5,6,7 with in_last on 7 → permuted state [5,6,7,0,...]; digest=[6,7,8,1,1,1,1,1].
- Two blocks: elements 1..12, in_last on 12.
  - After block 1, S=[2..9,1×8].
  - Block 2 overwrites elements 0..3 with 9..12 → digest=[10,11,12,13,7,8,9,10].
- Non-canonical input: 0x7FFFFFFF followed by 3 with in_last → perm_state_o element0=0 after the handshake; digest element0=1, element1=4.
- Backpressure: out_ready held low 5 cycles in SQUEEZE → out_valid stays 1, digest constant, in_ready=0. A handshake on cycle 6 returns to ABSORB with S=0.
- Reset mid-PERMUTE: assert rst_n low 10 cycles after last handshake → out_valid, busy and perm_state_o go 0 immediately, without a clock edge. After release, no digest appears; a new message 4 (last) yields digest [5,1,1,1,1,1,1,1].
